// File: rtl/seg_pkg.sv
// seg_pkg: digit codes, display-word type, scan states and digit selection shared by the scan controller.
package seg_pkg;

    typedef logic [4:0]  digit_t;
    typedef logic [19:0] disp_word_t;

    localparam digit_t DIG_0     = 5'd0;
    localparam digit_t DIG_1     = 5'd1;
    localparam digit_t DIG_2     = 5'd2;
    localparam digit_t DIG_3     = 5'd3;
    localparam digit_t DIG_4     = 5'd4;
    localparam digit_t DIG_5     = 5'd5;
    localparam digit_t DIG_6     = 5'd6;
    localparam digit_t DIG_7     = 5'd7;
    localparam digit_t DIG_8     = 5'd8;
    localparam digit_t DIG_9     = 5'd9;
    localparam digit_t DIG_L     = 5'd10;
    localparam digit_t DIG_R     = 5'd11;
    localparam digit_t DIG_I     = 5'd12;
    localparam digit_t DIG_N     = 5'd13;
    localparam digit_t DIG_T     = 5'd14;
    localparam digit_t DIG_BLANK = 5'b11111;

    // Scan state is the digit index itself: SCANn drives digit n.
    typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_e;

    function automatic digit_t digit_at(disp_word_t w, logic [1:0] i);
        return w[i*5 +: 5];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake and display pins; blink_mask exists only with SEG_SCAN_BLINK_EN.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic       load;
    disp_word_t digits_in;
    logic [3:0] dp_in;
    logic       ready;
    logic       load_ack;
    logic [3:0] an;
    logic [7:0] seg;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0] blink_mask;

    modport master (output load, digits_in, dp_in, blink_mask, input ready, load_ack, an, seg);
    modport slave  (input load, digits_in, dp_in, blink_mask, output ready, load_ack, an, seg);
`else
    modport master (output load, digits_in, dp_in, input ready, load_ack, an, seg);
    modport slave  (input load, digits_in, dp_in, output ready, load_ack, an, seg);
`endif

endinterface

// File: rtl/seg_scan_ctrl_codes.sv
// seg_codes: active-low 7-segment decoder (bits g..a) for digits, L r I n t; other codes blank.
module seg_codes
    import seg_pkg::*;
(
    input  digit_t     code_i,
    output logic [6:0] seg_n_o
);

    // Pure lookup; unused codes fall through to all segments off.
    always_comb begin
        seg_n_o = 7'h7F;
        case (code_i)
            DIG_0:   seg_n_o = 7'h40;
            DIG_1:   seg_n_o = 7'h79;
            DIG_2:   seg_n_o = 7'h24;
            DIG_3:   seg_n_o = 7'h30;
            DIG_4:   seg_n_o = 7'h19;
            DIG_5:   seg_n_o = 7'h12;
            DIG_6:   seg_n_o = 7'h02;
            DIG_7:   seg_n_o = 7'h78;
            DIG_8:   seg_n_o = 7'h00;
            DIG_9:   seg_n_o = 7'h10;
            DIG_L:   seg_n_o = 7'h47;
            DIG_R:   seg_n_o = 7'h2F;
            DIG_I:   seg_n_o = 7'h4F;
            DIG_N:   seg_n_o = 7'h2B;
            DIG_T:   seg_n_o = 7'h07;
            default: seg_n_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with double-buffered display word.
// Optional blinking is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    scan_e         state_q, state_d;
    disp_word_t    act_q, pend_q;
    logic [3:0]    act_dp_q, pend_dp_q;
    logic          ready_q, ack_q;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick, frame, accept, commit, blank;
    digit_t        cur_digit;
    logic [6:0]    pat;

    assign cur_digit = digit_at(act_q, state_q);

    seg_codes u_codes (
        .code_i  (cur_digit),
        .seg_n_o (pat)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] bcnt_q;
    logic          phase_q;
    logic [3:0]    act_bm_q, pend_bm_q;

    // Blink phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (frame) begin
            bcnt_q  <= (bcnt_q == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt_q + 1'b1;
            phase_q <= (bcnt_q == BW'(BLINK_FRAMES - 1)) ? ~phase_q : phase_q;
        end
    end

    // Blink mask follows the same pending/active path as the digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bm_q <= '0;
            act_bm_q  <= '0;
        end else begin
            if (accept) pend_bm_q <= bus.blink_mask;
            if (commit) act_bm_q  <= pend_bm_q;
        end
    end

    assign blank = phase_q && act_bm_q[state_q];
`else
    assign blank = 1'b0;
`endif

    // Next-state and display decode; the tick cycle produces the all-off guard.
    always_comb begin
        tick    = cnt_q == CW'(REFRESH_DIV - 1);
        frame   = tick && (state_q == SCAN3);
        accept  = bus.load && ready_q;
        commit  = frame && !ready_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        state_d = tick ? scan_e'(state_q + 2'd1) : state_q;
        an_d    = tick ? 4'b1111 : ~(4'b0001 << state_q);
        seg_d   = (tick || blank) ? 8'hFF : {~act_dp_q[state_q], pat};
    end

    // Refresh counter and scan state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= SCAN0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Pending word is held while ready is low and only moves to active on a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            pend_dp_q <= '0;
            act_q     <= {4{DIG_BLANK}};
            act_dp_q  <= '0;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= commit;
            if (accept) begin
                pend_q    <= bus.digits_in;
                pend_dp_q <= bus.dp_in;
                ready_q   <= 1'b0;
            end
            if (commit) begin
                act_q    <= pend_q;
                act_dp_q <= pend_dp_q;
                ready_q  <= 1'b1;
            end
        end
    end

    // Registered anode and cathode drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.load_ack = ack_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;

endmodule
